// File: rtl/blur_frame_ctrl.sv
// blur_frame_ctrl
// Frame sequencer wrapped around the 3x3 Gaussian blur core. It gates a
// ready/valid pixel source into the core's valid-only input. It tracks the
// input row/column so that only core outputs built from a full 3x3 window
// (interior pixels) are passed on. It tags the output stream with
// start-of-frame, end-of-line and end-of-frame markers.
//
// Parameters
//   IMG_W     image width in pixels (>=3), must match the core's line length
//   IMG_H     image height in lines (>=3)
//   PIPE_LAT  core latency from core_pix_vld to core_vld_out (>=1)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, abort       begin a frame (sampled in IDLE) / cancel the frame
//   busy, done, err    not-IDLE, one-cycle completion pulse, sticky mismatch
//   s_data/s_vld/s_rdy pixel source handshake
//   core_pix/_vld      pixel stream into the blur core
//   core_out/_vld_out  blurred stream from the blur core
//   m_data/m_vld       qualified output pixels, no backpressure
//   m_sof/m_eol/m_eof  frame and line markers, valid with m_vld

module blur_frame_ctrl #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int PIPE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  output logic       s_rdy,
  output logic [7:0] core_pix,
  output logic       core_pix_vld,
  input  logic [7:0] core_out,
  input  logic       core_vld_out,
  output logic [7:0] m_data,
  output logic       m_vld,
  output logic       m_sof,
  output logic       m_eol,
  output logic       m_eof
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] OCOL_LAST = CW'(IMG_W - 3);
  localparam logic [RW-1:0] OROW_LAST = RW'(IMG_H - 3);
  localparam logic [DW-1:0] DRN_LAST  = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     in_col;
  logic [RW-1:0]     in_row;
  logic [CW-1:0]     out_col;
  logic [RW-1:0]     out_row;
  logic [DW-1:0]     drain_cnt;
  logic [PIPE_LAT-1:0] qpipe;

  logic accept;
  logic frame_start;
  logic last_accept;
  logic qual;
  logic q_out;
  logic out_hit;

  assign accept       = s_vld & s_rdy;
  assign frame_start  = (state == ST_IDLE) & start & ~abort;
  assign last_accept  = accept & (in_col == COL_LAST) & (in_row == ROW_LAST);
  // Only windows whose bottom-right pixel is at row>=2, col>=2 are complete.
  assign qual         = accept & (in_row >= RW'(2)) & (in_col >= CW'(2));
  assign q_out        = qpipe[PIPE_LAT-1];
  assign out_hit      = q_out & core_vld_out;

  // Pass-through into the core; the pixel bus is parked at zero outside RUN.
  assign core_pix     = s_rdy ? s_data : 8'h00;
  assign core_pix_vld = accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    s_rdy     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy  = 1'b1;
        s_rdy = 1'b1;
        if (abort)            state_nxt = ST_IDLE;
        else if (last_accept) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (abort)                        state_nxt = ST_IDLE;
        else if (drain_cnt == DRN_LAST)   state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // DRAIN lasts PIPE_LAT cycles so the last qualified pixel has left the core.
  always_ff @(posedge clk) begin
    if (rst || state != ST_DRAIN || abort) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end

  // Input raster position; holds across s_vld gaps.
  always_ff @(posedge clk) begin
    if (rst || frame_start || abort) begin
      in_col <= '0;
      in_row <= '0;
    end else if (accept) begin
      if (in_col == COL_LAST) begin
        in_col <= '0;
        in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // The qualifier pipe mirrors the core latency so q_out lines up with core_vld_out.
  always_ff @(posedge clk) begin
    if (rst || frame_start || abort) begin
      qpipe <= '0;
    end else begin
      qpipe[0] <= qual;
      for (int i = 1; i < PIPE_LAT; i++) begin
        qpipe[i] <= qpipe[i-1];
      end
    end
  end

  // Output register stage plus output raster counters used for the markers.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      m_data  <= 8'h00;
      m_vld   <= 1'b0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
      m_eof   <= 1'b0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      m_vld <= out_hit;
      m_sof <= out_hit & (out_col == '0) & (out_row == '0);
      m_eol <= out_hit & (out_col == OCOL_LAST);
      m_eof <= out_hit & (out_col == OCOL_LAST) & (out_row == OROW_LAST);
      if (out_hit) m_data <= core_out;
      if (frame_start) begin
        out_col <= '0;
        out_row <= '0;
      end else if (out_hit) begin
        if (out_col == OCOL_LAST) begin
          out_col <= '0;
          out_row <= (out_row == OROW_LAST) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // A qualified slot without core data means the core and qualifier disagree.
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      err <= 1'b0;
    end else if (q_out && !core_vld_out) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_blur_frame_ctrl.sv
// tb_blur_frame_ctrl
// Directed bench for blur_frame_ctrl at 4x4, PIPE_LAT=1. A one-cycle core model
// returns pixel^0x5A for every input pixel so border windows are also valid
// and must be discarded. Expected outputs are queued as pixels are driven and
// popped by a monitor when m_vld appears.

module tb_blur_frame_ctrl;

  localparam int W   = 4;
  localparam int H   = 4;
  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       busy, done, err;
  logic [7:0] s_data;
  logic       s_vld, s_rdy;
  logic [7:0] core_pix;
  logic       core_pix_vld;
  logic [7:0] core_out = 8'h00;
  logic       core_vld_out = 1'b0;
  logic [7:0] m_data;
  logic       m_vld, m_sof, m_eol, m_eof;
  logic       kill = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   out_cnt = 0;
  int   exp_oc, exp_or;

  blur_frame_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .core_pix(core_pix), .core_pix_vld(core_pix_vld),
    .core_out(core_out), .core_vld_out(core_vld_out),
    .m_data(m_data), .m_vld(m_vld), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  always #5 clk = ~clk;

  // Blur core stand-in: one register stage, kill drops a valid to provoke err.
  always @(posedge clk) begin
    core_vld_out <= core_pix_vld & ~kill;
    core_out     <= core_pix ^ 8'h5A;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every m_vld, counts done pulses.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (m_vld) begin
      out_cnt++;
      if (sbq.size() == 0) begin
        checkOutput("unexpected_mvld", 32'(m_data), 32'h1FF);
      end else begin
        e = sbq.pop_front();
        checkOutput("m_data", 32'(m_data), 32'(e.d));
        checkOutput("m_sof", 32'(m_sof), 32'(e.sof));
        checkOutput("m_eol", 32'(m_eol), 32'(e.eol));
        checkOutput("m_eof", 32'(m_eof), 32'(e.eof));
      end
    end else begin
      checkOutput("markers_without_vld", 32'({m_sof, m_eol, m_eof}), 32'd0);
    end
  end

  task automatic pushExpected(input logic [7:0] pix);
    exp_t e;
    e.d   = pix ^ 8'h5A;
    e.sof = (exp_oc == 0) && (exp_or == 0);
    e.eol = (exp_oc == W - 3);
    e.eof = e.eol && (exp_or == H - 3);
    sbq.push_back(e);
    if (e.eol) begin
      exp_oc = 0;
      exp_or = e.eof ? 0 : exp_or + 1;
    end else begin
      exp_oc++;
    end
  endtask

  // One frame: gap alternates s_vld, cval>=0 gives a constant image,
  // abort_after cancels before that pixel index, kill_idx drops that core valid,
  // spam holds start high through RUN and DRAIN.
  task automatic applyStimulus(input bit gap, input int cval, input int abort_after,
                               input int kill_idx, input bit spam);
    int       idx, r, c, pushed, done_base, out_base, cyc;
    bit       hole, seen;
    logic [7:0] pix;
    idx = 0; pushed = 0; hole = 1'b0;
    exp_oc = 0; exp_or = 0;
    done_base = done_cnt;
    out_base  = out_cnt;
    start = 1'b1; s_vld = 1'b0;
    @(negedge clk);
    start = spam;
    checkOutput("busy_in_run", 32'(busy), 32'd1);
    checkOutput("err_cleared_by_start", 32'(err), 32'd0);
    while (idx < W * H) begin
      if (idx == abort_after) break;
      if (gap && hole) begin
        s_vld = 1'b0; s_data = 8'($urandom); kill = 1'b0;
        #1;
        checkOutput("s_rdy_in_gap", 32'(s_rdy), 32'd1);
        checkOutput("core_pix_vld_gap", 32'(core_pix_vld), 32'd0);
      end else begin
        r = idx / W; c = idx % W;
        pix = (cval >= 0) ? 8'(cval) : 8'(idx);
        s_vld = 1'b1; s_data = pix; kill = (idx == kill_idx);
        if (r >= 2 && c >= 2 && !kill) begin
          pushExpected(pix);
          pushed++;
        end
        #1;
        checkOutput("s_rdy_run", 32'(s_rdy), 32'd1);
        checkOutput("core_pix_vld", 32'(core_pix_vld), 32'd1);
        checkOutput("core_pix", 32'(core_pix), 32'(pix));
        idx++;
      end
      hole = ~hole;
      @(negedge clk);
    end
    s_vld = 1'b0; kill = 1'b0;
    if (abort_after >= 0) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      sbq.delete();
      repeat (4) @(negedge clk);
      checkOutput("abort_no_done", 32'(done_cnt - done_base), 32'd0);
      checkOutput("abort_no_mvld", 32'(out_cnt - out_base), 32'd0);
      checkOutput("abort_stays_idle", 32'(busy), 32'd0);
      return;
    end
    checkOutput("drain_s_rdy", 32'(s_rdy), 32'd0);
    checkOutput("drain_no_done", 32'(done), 32'd0);
    checkOutput("drain_busy", 32'(busy), 32'd1);
    cyc = 0; seen = 1'b0;
    while (cyc < 8 && !seen) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", 32'(seen), 32'd1);
    checkOutput("done_latency", 32'(cyc), 32'(LAT));
    checkOutput("last_mvld_with_done", 32'(m_vld), 32'd1);
    checkOutput("eof_with_done", 32'(m_eof), 32'(kill_idx < 0));
    @(negedge clk);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    checkOutput("busy_falls", 32'(busy), 32'd0);
    checkOutput("queue_drained", 32'(sbq.size()), 32'd0);
    checkOutput("frame_outputs", 32'(out_cnt - out_base), 32'(pushed));
    checkOutput("single_done", 32'(done_cnt - done_base), 32'd1);
    checkOutput("err_after_frame", 32'(err), 32'(kill_idx >= 0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    s_vld = 1'b1; s_data = 8'hAA;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_s_rdy", 32'(s_rdy), 32'd0);
    checkOutput("rst_core_pix_vld", 32'(core_pix_vld), 32'd0);
    checkOutput("rst_core_pix", 32'(core_pix), 32'd0);
    checkOutput("rst_m_vld", 32'(m_vld), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_markers", 32'({m_sof, m_eol, m_eof}), 32'd0);

    start = 1'b1;
    @(negedge clk);
    checkOutput("rst_beats_start", 32'(busy), 32'd0);
    rst = 1'b0; abort = 1'b1; s_vld = 1'b0;
    @(negedge clk);
    checkOutput("abort_beats_start", 32'(busy), 32'd0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);

    $display("[TB] contiguous ramp frame");
    applyStimulus(1'b0, -1, -1, -1, 1'b0);
    $display("[TB] gapped ramp frame, back to back");
    applyStimulus(1'b1, -1, -1, -1, 1'b0);
    $display("[TB] constant 0x80 frame");
    applyStimulus(1'b0, 8'h80, -1, -1, 1'b0);
    $display("[TB] abort after 10 pixels, then full frame");
    applyStimulus(1'b0, -1, 10, -1, 1'b0);
    applyStimulus(1'b0, -1, -1, -1, 1'b0);
    $display("[TB] dropped core valid, then clean frame");
    applyStimulus(1'b0, -1, -1, 10, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("err_sticky", 32'(err), 32'd1);
    applyStimulus(1'b0, 8'h33, -1, -1, 1'b0);
    $display("[TB] start held during RUN and DRAIN");
    applyStimulus(1'b1, -1, -1, -1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("spam_start_ignored", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/blur_frame_ctrl.md
Name: blur_frame_ctrl

Overview:
Frame sequencer wrapped around the 3x3 Gaussian blur core (window generator + 1-2-1 kernel, fixed-latency registered output).
- Gates a ready/valid pixel source into the core's valid-only input.
- Tracks input row/column and qualifies core outputs so only full-window (interior) pixels are emitted.
- Tags the output stream with frame/line markers and sequences start/busy/done per frame.

Parameters:
IMG_W, 32, image width in pixels; must match the core's window generator; >=3
IMG_H, 32, image height in lines; >=3
PIPE_LAT, 1, core latency: cycles from core_pix_vld to the matching core_vld_out; >=1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin one frame; sampled in IDLE only
abort  in  1  cancel current frame; highest priority after rst
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at frame completion
err  out  1  sticky; qualifier/core valid mismatch; cleared by rst or start
s_data  in  8  source pixel
s_vld  in  1  source valid
s_rdy  out  1  controller accepts pixel (RUN state only)
core_pix  out  8  pixel to blur core
core_pix_vld  out  1  pixel valid to blur core
core_out  in  8  blurred pixel from core
core_vld_out  in  1  core output valid
m_data  out  8  qualified output pixel
m_vld  out  1  output valid; no backpressure
m_sof  out  1  with m_vld: first output pixel of frame
m_eol  out  1  with m_vld: last output pixel of an output line
m_eof  out  1  with m_vld: last output pixel of frame

Behaviour:
- Reset: state IDLE. All counters, qualifier pipe, busy, done, err, s_rdy, core_pix_vld, m_vld, m_sof, m_eol, m_eof = 0. m_data and core_pix = 0.
- States:
  - IDLE: start -> RUN; clears in_col, in_row, out_col, out_row, qual pipe and err.
  - RUN: s_rdy=1. Accept = s_vld & s_rdy. Accept of pixel (IMG_W-1, IMG_H-1) -> DRAIN.
  - DRAIN: s_rdy=0. Wait exactly PIPE_LAT cycles -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- core_pix = s_data and core_pix_vld = accept, both combinational pass-through; no added latency.
- Input counters advance on accept only and hold during s_vld gaps:
  - in_col wraps IMG_W-1 -> 0 and increments in_row.
  - Counter widths are $clog2 of the dimension.
- Qualifier: qual = accept & (in_row>=2) & (in_col>=2), evaluated on pre-increment counters.
  - Shifts through a PIPE_LAT-deep pipe every cycle; a 0 enters when there is no accept.
  - Pipe output q_out aligns with core_vld_out.
- Output, registered one cycle after the q_out cycle:
  - m_vld = q_out & core_vld_out; m_data = core_out.
  - q_out & !core_vld_out -> err set, m_vld stays 0.
  - core_vld_out & !q_out -> discarded, no error (border windows).
- Output counters advance on m_vld; out_col wraps IMG_W-3 -> 0.
  - m_sof = m_vld & out_col==0 & out_row==0.
  - m_eol = m_vld & out_col==IMG_W-3.
  - m_eof = m_eol & out_row==IMG_H-3.
- Frame output count is (IMG_W-2)*(IMG_H-2) pixels; final m_vld arrives 1 cycle after the DRAIN->DONE transition, coincident with done.
- Simultaneous events:
  - start outside IDLE is ignored.
  - start with rst: rst wins.
  - abort in any state: next cycle IDLE. Counters, qual pipe and m_* cleared; no done pulse; err kept.
  - abort with start in IDLE: stay IDLE.
- Mid-frame rst behaves as full reset. The core's line buffers are not flushed; the first two lines of the next frame overwrite them, and those windows are never qualified.
- Back-to-back frames: start may be asserted in the cycle after done.

Test Plan:
- IMG_W=4, IMG_H=4, PIPE_LAT=1, start, 16 contiguous pixels 0..15 -> 4 m_vld pulses.
  - Markers: sof on #1, eol on #2 and #4, eof on #4.
  - done high in the same cycle as m_vld #4; busy falls the cycle after.
- Same frame with s_vld low every other cycle -> s_rdy=1 throughout RUN; identical 4 outputs and data; core_pix_vld toggles with s_vld.
- Constant pixel 0x80, default 32x32 -> 900 outputs all 0x80; exactly 30 eol, 1 sof, 1 eof; err=0.
- Abort after 10 accepted pixels (4x4) -> IDLE next cycle, busy=0, no done, no further m_vld. A following full frame yields 4 correct outputs.
- Core model holds core_vld_out=0 for one qualified cycle -> err=1 sticky, that output missing; next start clears err.
- start pulsed during RUN and during DRAIN -> no effect: single done, single frame count.
